byp_sb_unit: RTL
================

// Module: byp_sb_unit
// PURPOSE
//  Parametrised successor to the EX-stage bypass network. Adds a per-register
//  scoreboard counting in-flight writers, so multi-cycle producers (load/div)
//  raise a stall instead of silently missing the bypass. Priority forwarding is
//  generalised to NFWD stages and NSRC read ports. Sits between ID/RD and EX.
// PARAMETERS
//  XLEN     32  datapath width
//  NREG     32  architectural registers (x0 never tracked)
//  NSRC     2   source operands checked per cycle
//  NFWD     3   forwarding stages; index 0 = youngest (EX/MEM)
//  MAXPEND  3   max in-flight writers per register (counter saturates here)
//  RW       $clog2(NREG), derived, not overridable
// PORTS
//  clk           in   1            core clock
//  rst_n         in   1            asynchronous active-low reset
//  en            in   1            unit enable; 0 = outputs idle, state held
//  flush         in   1            pipeline flush: clear all scoreboard entries
//  iss_valid     in   1            instruction issuing from RD to EX this cycle
//  iss_rd        in   RW           its destination register
//  iss_has_rd    in   1            it writes rd
//  iss_ready     out  1            issue accepted (no stall, no saturation)
//  src_valid     in   NSRC         source operand i in use by RD-stage inst
//  src_reg       in   NSRC*RW      source register indices
//  fwd_valid     in   NFWD         stage k holds a valid writer
//  fwd_rdy       in   NFWD         stage k result is computed
//  fwd_rd        in   NFWD*RW      stage k destination
//  fwd_value     in   NFWD*XLEN    stage k result
//  wb_valid      in   1            writeback retiring a writer
//  wb_rd         in   RW           writeback destination
//  byp_hit       out  NSRC         operand i supplied by bypass
//  byp_value     out  NSRC*XLEN    bypassed operand values
//  stall         out  1            RD stage must hold
//  stall_cycles  out  32           saturating count of stalled cycles
// BEHAVIOUR
//  Reset (rst_n=0, async): all pend[r]=0, stall_cycles=0. Comb outputs then
//   read 0 (byp_hit=0, byp_value=0, stall=0, iss_ready=0).
//  en=0: comb outputs forced 0, state frozen, no counter update.
//  Forwarding, per operand i (comb, 0-cycle): scan k=0..NFWD-1, first k with
//   fwd_valid[k] && fwd_rd[k]==src_reg[i] selects. If fwd_rdy[k]: hit=1 and
//   value=fwd_value[k]. Otherwise the operand is unresolved. A match at a
//   younger stage masks older ones even when not ready.
//   src_reg=0 never hits, never stalls. Unused operands: hit=0, value=0.
//  Operand needs stall: src_valid[i] && src_reg!=0 && pend[src_reg]!=0 &&
//   !byp_hit[i]. Writers past the last fwd stage but before wb therefore stall.
//  stall = any operand needs stall. iss_ready = iss_valid && !stall && !sat,
//   where sat = iss_has_rd && iss_rd!=0 && pend[iss_rd]==MAXPEND.
//  Scoreboard update (posedge, en=1):
//   inc = iss_ready && iss_has_rd && iss_rd!=0; dec = wb_valid && wb_rd!=0.
//   Same register with inc and dec: net 0. dec when pend==0: hold at 0 and
//    assert SVA error (protocol violation).
//   flush=1: every pend cleared to 0; inc/dec of that cycle ignored.
//  stall_cycles += 1 on each en cycle with (stall || sat) && iss_valid;
//   holds at 32'hFFFF_FFFF. Not cleared by flush.
//  Latency: bypass/stall comb same cycle; scoreboard change visible next cycle.
// TESTING
//  1. Reset, issue x5 writer, next cycle operand rs1=x5 with stage0 valid,
//     rdy, value 0xDEAD -> byp_hit[0]=1, byp_value=0xDEAD, stall=0.
//  2. Load to x7 in stage0 with fwd_rdy=0 and pend[x7]=1 -> stall=1,
//     iss_ready=0. Next cycle rdy=1, value 0x55 -> stall=0, hit, 0x55.
//  3. Stage0 and stage2 both write x3 (0x1, 0x2) -> value 0x1. Stage0 not
//     ready -> stall despite stage2 being ready.
//  4. Issue 3 writers to x9 (MAXPEND=3) then a 4th -> iss_ready=0 and
//     stall_cycles increments. Same-cycle issue + wb to x9 at pend=2 -> pend
//     stays 2.
//  5. pend[x4]=2, flush with concurrent issue to x4 -> all pend=0 next cycle,
//     operand x4 no stall. Async rst_n pulse mid-stall -> stall=0 immediately.
//  6. Operand x0 with stage0 writing x0 -> hit=0, stall=0. wb to a register
//     with pend=0 -> SVA fires, pend stays 0.

Source files
------------

// File: rtl/byp_sb_unit.sv
// byp_sb_unit: EX-stage bypass network with a per-register scoreboard.
//
// Forwards results from NFWD pipeline stages to NSRC read-stage operands. It
// also counts in-flight writers per architectural register. An operand whose
// register has outstanding writers, and that no stage can supply, raises a
// stall. Multi-cycle producers therefore hold the RD stage instead of
// silently reading a stale register file value.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   en                    unit enable (0: comb outputs idle, state frozen)
//   flush                 clears every scoreboard entry
//   iss_valid/iss_ready   issue handshake RD->EX (see below)
//   iss_rd, iss_has_rd    destination of the issuing instruction
//   src_valid, src_reg    per-operand source register requests
//   fwd_valid/rdy/rd/value  per-stage writer info, index 0 = youngest
//   wb_valid, wb_rd       writeback retiring one writer
//   byp_hit, byp_value    per-operand bypass result
//   stall                 RD stage must hold
//   stall_cycles          saturating count of blocked issue attempts
//
// Handshake: an instruction moves from RD into EX on a cycle where both
// iss_valid and iss_ready are high. iss_ready is a combinational function of
// iss_valid, so the producer may not wait for ready before raising valid.
// While valid is high and ready is low, the producer holds the instruction
// and retries it on a later cycle.
module byp_sb_unit #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NSRC    = 2,
    parameter int NFWD    = 3,
    parameter int MAXPEND = 3,
    localparam int RW     = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 iss_valid,
    input  logic [RW-1:0]        iss_rd,
    input  logic                 iss_has_rd,
    output logic                 iss_ready,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [NSRC*RW-1:0]   src_reg,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_rdy,
    input  logic [NFWD*RW-1:0]   fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_value,
    input  logic                 wb_valid,
    input  logic [RW-1:0]        wb_rd,
    output logic [NSRC-1:0]      byp_hit,
    output logic [NSRC*XLEN-1:0] byp_value,
    output logic                 stall,
    output logic [31:0]          stall_cycles
);

    localparam int PW = $clog2(MAXPEND + 1);

    logic [PW-1:0]        pend [NREG];
    logic [NSRC-1:0]      hit_raw;
    logic [NSRC*XLEN-1:0] val_raw;
    logic [NSRC-1:0]      need_stall;
    logic                 matched;
    logic [RW-1:0]        sreg;
    logic                 stall_raw;
    logic                 sat_raw;
    logic                 inc;
    logic                 dec;

    // Priority scan: the youngest matching stage owns the operand. If that
    // stage is not ready yet, it still masks older ready stages, because
    // their values are stale relative to the pending write.
    always_comb begin
        hit_raw    = '0;
        val_raw    = '0;
        need_stall = '0;
        matched    = 1'b0;
        sreg       = '0;
        for (int i = 0; i < NSRC; i++) begin
            matched = 1'b0;
            sreg    = src_reg[i*RW +: RW];
            for (int k = 0; k < NFWD; k++) begin
                if (!matched && fwd_valid[k] && (fwd_rd[k*RW +: RW] == sreg)) begin
                    matched = 1'b1;
                    if (fwd_rdy[k]) begin
                        hit_raw[i]                = 1'b1;
                        val_raw[i*XLEN +: XLEN]   = fwd_value[k*XLEN +: XLEN];
                    end
                end
            end
            // x0 is hardwired zero and unused operands stay quiet.
            if (!src_valid[i] || (sreg == '0)) begin
                hit_raw[i]              = 1'b0;
                val_raw[i*XLEN +: XLEN] = '0;
            end
            need_stall[i] = src_valid[i] && (sreg != '0) &&
                            (pend[sreg] != '0) && !hit_raw[i];
        end
    end

    assign stall_raw = |need_stall;
    assign sat_raw   = iss_has_rd && (iss_rd != '0) && (pend[iss_rd] == PW'(MAXPEND));

    assign stall     = en && stall_raw;
    assign iss_ready = en && iss_valid && !stall_raw && !sat_raw;
    assign byp_hit   = en ? hit_raw : '0;
    assign byp_value = en ? val_raw : '0;

    assign inc = iss_ready && iss_has_rd && (iss_rd != '0);
    assign dec = wb_valid && (wb_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) pend[r] <= '0;
            stall_cycles <= '0;
        end else if (en) begin
            if (flush) begin
                for (int r = 0; r < NREG; r++) pend[r] <= '0;
            end else begin
                for (int r = 1; r < NREG; r++) begin
                    if (inc && (iss_rd == RW'(r)) && !(dec && (wb_rd == RW'(r)))) begin
                        pend[r] <= pend[r] + PW'(1);
                    end else if (dec && (wb_rd == RW'(r)) && !(inc && (iss_rd == RW'(r))) &&
                                 (pend[r] != '0)) begin
                        pend[r] <= pend[r] - PW'(1);
                    end
                end
            end
            if ((stall_raw || sat_raw) && iss_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

    // A writeback with no matching in-flight writer means the pipeline lost
    // track of a producer. The counter holds at 0, but this is a real bug.
    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        (en && !flush && dec && !(inc && (iss_rd == wb_rd))) |-> (pend[wb_rd] != '0)
    ) else $error("byp_sb_unit: writeback to register %0d with no pending writer", wb_rd);

endmodule
